// File: rtl/sum_accumulator_if.sv
// Operand stream in, burst result out: valid/ready on both sides.
interface sum_accumulator_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [CNT_W-1:0] out_carries;
  logic [CNT_W-1:0] out_count;

  // Accumulator side: consumes operands, produces the result.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_carries, out_count
  );

  // Producer/consumer side.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_carries, out_count
  );
endinterface

// File: rtl/sum_accumulator.sv
// Adds a burst of operands into a running sum, counting beats and carry-outs.
// Latency: result valid one cycle after the last beat is accepted.
// Backpressure: in_ready drops while a result waits; result held until out_ready.
module sum_accumulator #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input logic             clk,
  input logic             rst_n,
  sum_accumulator_if.slave io
);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] carries;
  logic [CNT_W-1:0] count;
  logic [WIDTH:0]   sum_ext;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != '1)) ? v + 1'b1 : v;
  endfunction

  assign sum_ext = {1'b0, acc} + {1'b0, io.in_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_ACC;
      acc     <= '0;
      carries <= '0;
      count   <= '0;
    end else begin
      case (state)
        ST_ACC: begin
          if (io.in_valid) begin
            acc     <= sum_ext[WIDTH-1:0];
            carries <= sat_inc(carries, sum_ext[WIDTH]);
            count   <= sat_inc(count, 1'b1);
            if (io.in_last) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Clearing on the handshake edge means the next burst starts from zero.
          if (io.out_ready) begin
            acc     <= '0;
            carries <= '0;
            count   <= '0;
            state   <= ST_ACC;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

  assign io.in_ready    = (state == ST_ACC);
  assign io.out_valid   = (state == ST_DONE);
  assign io.out_sum     = acc;
  assign io.out_carries = carries;
  assign io.out_count   = count;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed vector table, hand-written corner sequences and random bursts against a reference model.
module tb_sum_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sum_accumulator_if #(.WIDTH(32), .CNT_W(8)) io ();

  sum_accumulator #(.WIDTH(32), .CNT_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (io.slave)
  );

  typedef struct {
    int          n;
    logic [31:0] d[4];
    logic [31:0] exp_sum;
    int          exp_carries;
    int          exp_count;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one beat at a negedge, return at the negedge after it is accepted.
  task automatic send(input logic [31:0] d, input logic l);
    int w = 0;
    io.in_valid = 1'b1;
    io.in_data  = d;
    io.in_last  = l;
    while (io.in_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stuck at %b, expected 1", io.in_ready);
    end
    @(negedge clk);
    io.in_valid = 1'b0;
  endtask

  task automatic take(input string tag, input logic [31:0] es, input int ec, input int en, input int dly);
    int w = 0;
    while (io.out_valid !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: out_valid stuck at %b, expected 1", tag, io.out_valid);
    end
    check({tag, "_sum"},     64'(io.out_sum),     64'(es));
    check({tag, "_carries"}, 64'(io.out_carries), 64'(ec));
    check({tag, "_count"},   64'(io.out_count),   64'(en));
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 64'(io.out_valid), 64'd1);
      check({tag, "_hold_sum"},   64'(io.out_sum),   64'(es));
    end
    io.out_ready = 1'b1;
    @(negedge clk);
    io.out_ready = 1'b0;
    check({tag, "_post_ready"}, 64'(io.in_ready),  64'd1);
    check({tag, "_post_valid"}, 64'(io.out_valid), 64'd0);
    check({tag, "_post_count"}, 64'(io.out_count), 64'd0);
  endtask

  vec_t vt[5];

  initial begin
    logic [63:0] total;
    int          n, len, dly;
    logic [31:0] d;

    vt[0] = '{3, '{32'd1, 32'd2, 32'd3, 32'd0}, 32'd6, 0, 3};
    vt[1] = '{2, '{32'hFFFF_FFFF, 32'h2, 32'd0, 32'd0}, 32'h1, 1, 2};
    vt[2] = '{1, '{32'd4, 32'd0, 32'd0, 32'd0}, 32'd4, 0, 1};
    vt[3] = '{2, '{32'd9, 32'd1, 32'd0, 32'd0}, 32'd10, 0, 2};
    vt[4] = '{3, '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'd0}, 32'h8000_0000, 1, 3};

    io.in_valid  = 1'b0;
    io.in_data   = '0;
    io.in_last   = 1'b0;
    io.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_in_ready",  64'(io.in_ready),    64'd1);
    check("rst_out_valid", 64'(io.out_valid),   64'd0);
    check("rst_sum",       64'(io.out_sum),     64'd0);
    check("rst_carries",   64'(io.out_carries), 64'd0);
    check("rst_count",     64'(io.out_count),   64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Vector table
    foreach (vt[k]) begin
      for (int i = 0; i < vt[k].n; i++) begin
        send(vt[k].d[i], i == vt[k].n - 1);
        check($sformatf("vec%0d_valid_b%0d", k, i), 64'(io.out_valid), (i == vt[k].n - 1) ? 64'd1 : 64'd0);
      end
      take($sformatf("vec%0d", k), vt[k].exp_sum, vt[k].exp_carries, vt[k].exp_count, k % 2);
    end

    // Result held under backpressure; in_valid ignored meanwhile
    send(32'hDEAD_BEEF, 1'b1);
    io.in_valid = 1'b1;
    io.in_data  = 32'h1234_5678;
    io.in_last  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("hold_out_valid", 64'(io.out_valid),   64'd1);
      check("hold_in_ready",  64'(io.in_ready),    64'd0);
      check("hold_sum",       64'(io.out_sum),     64'h0000_0000_DEAD_BEEF);
      check("hold_carries",   64'(io.out_carries), 64'd0);
      check("hold_count",     64'(io.out_count),   64'd1);
      @(negedge clk);
    end
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    @(negedge clk);
    io.out_ready = 1'b0;
    check("hold_clear_sum",   64'(io.out_sum),   64'd0);
    check("hold_clear_count", 64'(io.out_count), 64'd0);
    check("hold_clear_ready", 64'(io.in_ready),  64'd1);

    // Long burst: sum wraps, both counters saturate
    for (int i = 0; i < 300; i++) send(32'hFFFF_FFFF, i == 299);
    take("sat", 32'hFFFF_FED4, 255, 255, 0);

    // Reset mid-burst discards the partial burst
    send(32'd7, 1'b0);
    send(32'd7, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_sum",   64'(io.out_sum),   64'd0);
    check("midrst_count", 64'(io.out_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_out_valid", 64'(io.out_valid), 64'd0);
    @(negedge clk);
    send(32'd5, 1'b1);
    take("after_rst", 32'd5, 0, 1, 0);

    // Back-to-back bursts with in_valid held high across DONE
    io.in_valid = 1'b1;
    io.in_data  = 32'd4;
    io.in_last  = 1'b1;
    @(negedge clk);
    io.in_data = 32'd9;
    io.in_last = 1'b0;
    repeat (2) begin
      check("b2b_in_ready", 64'(io.in_ready),  64'd0);
      check("b2b_sum1",     64'(io.out_sum),   64'd4);
      check("b2b_count1",   64'(io.out_count), 64'd1);
      @(negedge clk);
    end
    io.out_ready = 1'b1;
    @(negedge clk);
    io.out_ready = 1'b0;
    check("b2b_cleared_count", 64'(io.out_count), 64'd0);
    check("b2b_ready_again",   64'(io.in_ready),  64'd1);
    @(negedge clk);
    io.in_data = 32'd1;
    io.in_last = 1'b1;
    @(negedge clk);
    io.in_valid = 1'b0;
    take("b2b2", 32'd10, 0, 2, 1);

    // Random bursts against the model: carries equal the overflow of the exact total
    for (int b = 0; b < 40; b++) begin
      total = '0;
      n     = 0;
      len   = (b % 8 == 0) ? $urandom_range(250, 270) : $urandom_range(1, 20);
      for (int i = 0; i < len; i++) begin
        d = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255))) : 32'($urandom);
        total += 64'(d);
        n++;
        send(d, i == len - 1);
        if (i != len - 1 && $urandom_range(0, 3) == 0) begin
          io.in_last = 1'b1;
          io.in_data = 32'($urandom);
          repeat ($urandom_range(1, 3)) @(negedge clk);
        end
      end
      dly = $urandom_range(0, 3);
      take($sformatf("rand%0d", b), total[31:0],
           (total[63:32] > 64'd255) ? 255 : int'(total[63:32]),
           (n > 255) ? 255 : n, dly);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
